traffic_queue_sim: RTL and testbench

//  Street-side model and safety monitor for the two-street traffic light controller.
//  - Consumes the controller's light codes la/lb.
//  - Keeps a car-queue count per street, fed by arrival buttons.
//  - Drives the controller's traffic sensors sa/sb.
//  - Flags unsafe or invalid light combinations.
//  - Closes the loop on the FPGA board; also serves as the controller's bench partner.

---
 rtl/tls_pkg.sv | 15 +
 rtl/traffic_queue_sim_if.sv | 28 ++
 rtl/tqs_lane.sv | 70 +++++++
 rtl/traffic_queue_sim.sv | 62 ++++++
 tb/tb_traffic_queue_sim.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/tls_pkg.sv
// Light-code definitions shared by the traffic light controller and its street-side model.
// Also holds the validity helper used by the safety monitor.
package tls_pkg;

  typedef logic [2:0] light_t;

  localparam light_t LIGHT_GREEN  = 3'b110;
  localparam light_t LIGHT_YELLOW = 3'b100;
  localparam light_t LIGHT_RED    = 3'b111;

  function automatic logic is_valid_light(input light_t code);
    return (code == LIGHT_GREEN) || (code == LIGHT_YELLOW) || (code == LIGHT_RED);
  endfunction

endpackage

// File: rtl/traffic_queue_sim_if.sv
// Street-side bus between the light controller and the queue model.
// Carries the light codes, arrival buttons, sensors, queue counts and safety flags.
interface traffic_queue_sim_if #(
  parameter int QW = 4
);
  tls_pkg::light_t la;
  tls_pkg::light_t lb;
  logic            arr_a;
  logic            arr_b;
  logic            sa;
  logic            sb;
  logic [QW-1:0]   qa;
  logic [QW-1:0]   qb;
  logic            conflict;
  logic            bad_code;

  // Controller / board side: drives lights and buttons, observes the street.
  modport master (
    output la, lb, arr_a, arr_b,
    input  sa, sb, qa, qb, conflict, bad_code
  );

  // Street model side.
  modport slave (
    input  la, lb, arr_a, arr_b,
    output sa, sb, qa, qb, conflict, bad_code
  );
endinterface

// File: rtl/tqs_lane.sv
// One street lane: button synchroniser, arrival edge detector, saturating
// up/down car counter and the registered "cars waiting" sensor.
module tqs_lane
  import tls_pkg::*;
#(
  parameter int QW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arr,
  input  light_t        light,
  input  logic          tick,
  output logic [QW-1:0] q,
  output logic          sensor
);

  localparam logic [QW-1:0] Q_MAX = '1;

  logic          sync_1, sync_2, sync_prev;
  logic          warm_1, warm_2, armed;
  logic          arrival, departure;
  logic [QW-1:0] q_next;

  // The edge detector arms only once a genuinely sampled low has flushed through
  // the synchroniser, so a button held across reset release never counts.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
      warm_1    <= 1'b0;
      warm_2    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sync_1    <= arr;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      warm_1    <= 1'b1;
      warm_2    <= warm_1;
      armed     <= armed | (warm_2 & ~sync_2);
    end
  end

  assign arrival   = sync_2 & ~sync_prev & armed;
  assign departure = tick && (light == LIGHT_GREEN) && (q != '0);

  // NOTE: q_next gets its default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    q_next = q;
    if (arrival && !departure && (q != Q_MAX)) begin
      q_next = q + QW'(1);
    end else if (departure && !arrival) begin
      q_next = q - QW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q      <= '0;
      sensor <= 1'b0;
    end else begin
      q      <= q_next;
      sensor <= (q_next != '0);
    end
  end

endmodule

// File: rtl/traffic_queue_sim.sv
// Street-side model and safety monitor for the two-street light controller:
// departure tick divider, two lane queues and sticky conflict / bad-code flags.
module traffic_queue_sim
  import tls_pkg::*;
#(
  parameter int QW       = 4,
  parameter int TICK_DIV = 100_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  traffic_queue_sim_if.slave   bus
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  tqs_lane #(.QW(QW)) u_lane_a (
    .clk    (clk),
    .reset  (reset),
    .arr    (bus.arr_a),
    .light  (bus.la),
    .tick   (tick),
    .q      (bus.qa),
    .sensor (bus.sa)
  );

  tqs_lane #(.QW(QW)) u_lane_b (
    .clk    (clk),
    .reset  (reset),
    .arr    (bus.arr_b),
    .light  (bus.lb),
    .tick   (tick),
    .q      (bus.qb),
    .sensor (bus.sb)
  );

  // Invalid codes are never RED, so they also count toward a conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.conflict <= 1'b0;
      bus.bad_code <= 1'b0;
    end else begin
      bus.conflict <= bus.conflict | ((bus.la != LIGHT_RED) && (bus.lb != LIGHT_RED));
      bus.bad_code <= bus.bad_code | !is_valid_light(bus.la) | !is_valid_light(bus.lb);
    end
  end

endmodule

// File: tb/tb_traffic_queue_sim.sv
// Directed bench for traffic_queue_sim: a queue-level street model compared every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_traffic_queue_sim;
  import tls_pkg::*;

  localparam int QW       = 2;
  localparam int TICK_DIV = 4;
  localparam int QMAX     = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  traffic_queue_sim_if #(.QW(QW)) bus ();

  traffic_queue_sim #(.QW(QW), .TICK_DIV(TICK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Street model: edges counted from reset release; a press first seen after edge k-1
  // yields a car at edge k+2; ticks fall on edges where index mod TICK_DIV == TICK_DIV-1.
  int edge_n;
  int m_qa, m_qb;
  bit m_conf, m_bad;
  int pend_a[$];
  int pend_b[$];
  bit m_tick, m_arr_a, m_arr_b;

  function automatic int lane_next(int q, bit arr, bit tick, light_t light);
    bit dep;
    dep = tick && (light == LIGHT_GREEN) && (q > 0);
    if (arr && dep) return q;
    if (arr) return (q < QMAX) ? q + 1 : QMAX;
    if (dep) return q - 1;
    return q;
  endfunction

  function automatic bit valid_code(light_t c);
    return (c == 3'b110) || (c == 3'b100) || (c == 3'b111);
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        edge_n = 0; m_qa = 0; m_qb = 0; m_conf = 0; m_bad = 0;
        pend_a.delete(); pend_b.delete();
      end else begin
        m_tick  = (edge_n % TICK_DIV) == TICK_DIV - 1;
        m_arr_a = 0;
        m_arr_b = 0;
        if (pend_a.size() > 0 && pend_a[0] == edge_n) begin m_arr_a = 1; void'(pend_a.pop_front()); end
        if (pend_b.size() > 0 && pend_b[0] == edge_n) begin m_arr_b = 1; void'(pend_b.pop_front()); end
        m_qa = lane_next(m_qa, m_arr_a, m_tick, bus.la);
        m_qb = lane_next(m_qb, m_arr_b, m_tick, bus.lb);
        if (bus.la != 3'b111 && bus.lb != 3'b111) m_conf = 1;
        if (!valid_code(bus.la) || !valid_code(bus.lb)) m_bad = 1;
        edge_n++;
      end
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("qa",       bus.qa,       m_qa);
      check("qb",       bus.qb,       m_qb);
      check("sa",       bus.sa,       int'(m_qa != 0));
      check("sb",       bus.sb,       int'(m_qb != 0));
      check("conflict", bus.conflict, m_conf);
      check("bad_code", bus.bad_code, m_bad);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a falling edge; holds the button for 3 cycles.
  task automatic press(input bit lane_b);
    if (lane_b) begin bus.arr_b = 1'b1; pend_b.push_back(edge_n + 2); end
    else        begin bus.arr_a = 1'b1; pend_a.push_back(edge_n + 2); end
    cycles(3);
    bus.arr_a = 1'b0;
    bus.arr_b = 1'b0;
    cycles(3);
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((((edge_n - 1) % TICK_DIV) != TICK_DIV - 1) && k < 20);
    if (k >= 20) check("tick_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_qa"},       bus.qa,       0);
    check({tag, "_qb"},       bus.qb,       0);
    check({tag, "_sa"},       bus.sa,       0);
    check({tag, "_sb"},       bus.sb,       0);
    check({tag, "_conflict"}, bus.conflict, 0);
    check({tag, "_bad_code"}, bus.bad_code, 0);
  endtask

  initial begin
    int k;
    bus.la = LIGHT_RED; bus.lb = LIGHT_RED;
    bus.arr_a = 1'b0;   bus.arr_b = 1'b0;
    reset = 1'b1;
    cycles(2);
    check_all_zero("reset");
    reset = 1'b0;
    cmp_en = 1;
    cycles(4);

    // Three presses with RED lights.
    repeat (3) press(1'b0);
    check("three_presses_qa", bus.qa, 3);
    check("three_presses_sa", bus.sa, 1);
    check("three_presses_qb", bus.qb, 0);
    check("three_presses_sb", bus.sb, 0);

    // Saturation.
    repeat (5) press(1'b0);
    check("saturate_qa", bus.qa, 3);

    // Departures on GREEN ticks, never below zero.
    bus.la = LIGHT_GREEN;
    wait_tick(); check("tick1_qa", bus.qa, 2);
    wait_tick(); check("tick2_qa", bus.qa, 1);
    wait_tick(); check("tick3_qa", bus.qa, 0); check("tick3_sa", bus.sa, 0);
    wait_tick(); check("tick4_qa", bus.qa, 0);
    bus.la = LIGHT_RED;
    cycles(1);

    // Arrival coinciding with a GREEN departure tick.
    repeat (2) press(1'b0);
    check("pre_tick_press_qa", bus.qa, 2);
    k = 0;
    while ((edge_n % TICK_DIV) != 1 && k < 20) begin @(negedge clk); k++; end
    bus.la = LIGHT_GREEN;
    bus.arr_a = 1'b1;
    pend_a.push_back(edge_n + 2);
    cycles(3);
    bus.la = LIGHT_RED;
    check("tick_and_press_qa", bus.qa, 2);
    cycles(2);
    bus.arr_a = 1'b0;
    cycles(3);

    // Lane B fill and drain.
    repeat (2) press(1'b1);
    check("lane_b_qb", bus.qb, 2);
    check("lane_b_sb", bus.sb, 1);
    bus.lb = LIGHT_GREEN;
    wait_tick(); wait_tick();
    bus.lb = LIGHT_RED;
    cycles(1);
    check("lane_b_drained_qb", bus.qb, 0);
    check("lane_b_drained_sb", bus.sb, 0);
    check("no_conflict_yet", bus.conflict, 0);

    // Conflict is sticky.
    bus.la = LIGHT_GREEN; bus.lb = LIGHT_YELLOW;
    cycles(1);
    bus.lb = LIGHT_RED; bus.la = LIGHT_RED;
    cycles(3);
    check("conflict_sticky", bus.conflict, 1);
    check("no_bad_code_yet", bus.bad_code, 0);

    // Invalid code is sticky.
    bus.la = 3'b000;
    cycles(1);
    bus.la = LIGHT_RED;
    cycles(2);
    check("bad_code_sticky", bus.bad_code, 1);

    // Asynchronous reset away from a clock edge, with a press held across release.
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    bus.arr_a = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cycles(6);
    bus.arr_a = 1'b0;
    cycles(3);
    check("held_press_no_car", bus.qa, 0);
    press(1'b0);
    check("press_after_reset_qa", bus.qa, 1);
    check("flags_after_reset", int'(bus.conflict) + int'(bus.bad_code), 0);

    cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
